// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, fetch states, reset NOP.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_NONE    = 2'd0,
        FWD_MEM_ALU = 2'd1,
        FWD_WB      = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        F_REQ  = 1'b0,
        F_HELD = 1'b1
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Per-operand bypass select: MEM ALU result beats WB, x0 never forwarded.
// Zero latency, purely combinational; no flow control.
module fwd_select
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic                 mem_wr_i,
    input  logic                 mem_load_i,
    input  logic [REG_IDX_W-1:0] mem_rd_i,
    input  logic                 wb_wr_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    output fwd_sel_t             sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (rs_i != '0) begin
            // A load in MEM has no data yet, so only ALU results bypass from MEM.
            if (mem_wr_i && !mem_load_i && (mem_rd_i == rs_i)) begin
                sel_o = FWD_MEM_ALU;
            end else if (wb_wr_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline, with fetch buffering and stall counting.
// Controls are combinational from inputs and state; backpressure freezes stages via load enables.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               REG_IDX_W = 5,
    parameter int               MC_CYCLES = 4,
    parameter int               CNT_W     = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(RV_NOP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [1:0]           id_use_rs,
    input  logic                 id_redirect,
    input  logic [REG_IDX_W-1:0] ex_rs1,
    input  logic [REG_IDX_W-1:0] ex_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wr,
    input  logic                 ex_load,
    input  logic                 ex_mc,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_wr,
    input  logic                 mem_load,
    input  logic                 mem_dreq,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_wr,
    input  logic [XLEN-1:0]      instr_mem_rdata,
    input  logic                 instr_mem_resp,
    input  logic                 data_mem_resp,
    output logic                 instr_read,
    output logic [XLEN-1:0]      if_ir,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic [1:0]           id_fwd_a,
    output logic [1:0]           id_fwd_b,
    output logic [1:0]           ex_fwd_a,
    output logic [1:0]           ex_fwd_b,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam int              MC_W    = $clog2(MC_CYCLES);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    fwd_sel_t id_sel_a, id_sel_b, ex_sel_a, ex_sel_b;
    logic     hz_a, hz_b, id_hazard, mc_busy, fetch_rdy;
    logic [4:0] ld;
    logic [2:0] fl;

    // A load in EX is already covered by the ex_wr check.
    logic unused_ex_load;
    assign unused_ex_load = ex_load;

    fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_id_a (
        .rs_i(id_rs1), .mem_wr_i(mem_wr), .mem_load_i(mem_load), .mem_rd_i(mem_rd),
        .wb_wr_i(wb_wr), .wb_rd_i(wb_rd), .sel_o(id_sel_a));
    fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_id_b (
        .rs_i(id_rs2), .mem_wr_i(mem_wr), .mem_load_i(mem_load), .mem_rd_i(mem_rd),
        .wb_wr_i(wb_wr), .wb_rd_i(wb_rd), .sel_o(id_sel_b));
    fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_ex_a (
        .rs_i(ex_rs1), .mem_wr_i(mem_wr), .mem_load_i(mem_load), .mem_rd_i(mem_rd),
        .wb_wr_i(wb_wr), .wb_rd_i(wb_rd), .sel_o(ex_sel_a));
    fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_ex_b (
        .rs_i(ex_rs2), .mem_wr_i(mem_wr), .mem_load_i(mem_load), .mem_rd_i(mem_rd),
        .wb_wr_i(wb_wr), .wb_rd_i(wb_rd), .sel_o(ex_sel_b));

    assign hz_a = id_use_rs[0] && (id_rs1 != '0) &&
                  ((ex_wr && (ex_rd == id_rs1)) || (mem_load && (mem_rd == id_rs1)));
    assign hz_b = id_use_rs[1] && (id_rs2 != '0) &&
                  ((ex_wr && (ex_rd == id_rs2)) || (mem_load && (mem_rd == id_rs2)));
    assign id_hazard = hz_a || hz_b;
    assign mc_busy   = ex_mc && (mc_cnt_q < MC_LAST);
    assign fetch_rdy = ((state_q == F_REQ) && instr_mem_resp) || (state_q == F_HELD);

    // ld = {pc, if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, ex_mem}
    always_comb begin
        ld = 5'b11111;
        fl = 3'b000;
        if (mem_dreq && !data_mem_resp) begin
            ld = 5'b00000;
        end else if (mc_busy) begin
            ld = 5'b00011;
            fl = 3'b001;
        end else if (id_hazard || (!fetch_rdy && id_redirect)) begin
            ld = 5'b00111;
            fl = 3'b010;
        end else if (!fetch_rdy) begin
            ld = 5'b01111;
            fl = 3'b100;
        end else begin
            fl = {id_redirect, 2'b00};
        end
    end

    assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = rst ? ld : 5'b00000;
    assign {flush_if_id, flush_id_ex, flush_ex_mem}                    = rst ? fl : 3'b000;
    assign id_fwd_a     = rst ? id_sel_a : FWD_NONE;
    assign id_fwd_b     = rst ? id_sel_b : FWD_NONE;
    assign ex_fwd_a     = rst ? ex_sel_a : FWD_NONE;
    assign ex_fwd_b     = rst ? ex_sel_b : FWD_NONE;
    assign instr_read   = rst && (state_q == F_REQ);
    assign if_ir        = (state_q == F_HELD) ? buf_q : instr_mem_rdata;
    assign stall_cycles = stall_q;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        mc_cnt_d = mc_cnt_q;
        stall_d  = stall_q;
        case (state_q)
            F_REQ: begin
                if (instr_mem_resp && !load_pc) begin
                    buf_d   = instr_mem_rdata;
                    state_d = F_HELD;
                end
            end
            F_HELD: begin
                if (load_pc) begin
                    state_d = F_REQ;
                end
            end
            default: state_d = F_REQ;
        endcase
        if (load_ex_mem && !flush_ex_mem) begin
            mc_cnt_d = '0;
        end else if (mc_busy) begin
            mc_cnt_d = mc_cnt_q + MC_W'(1);
        end
        if (!load_pc && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= F_REQ;
            buf_q    <= NOP_INSTR;
            mc_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            mc_cnt_q <= mc_cnt_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: vector table, directed multi-cycle sequences, random vs. model.
module tb_pipeline_hazard_unit;
    import pipeline_hazard_unit_pkg::*;

    localparam int MC    = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic        clk, rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic [1:0]  id_use_rs;
    logic        id_redirect, ex_wr, ex_load, ex_mc, mem_wr, mem_load, mem_dreq, wb_wr;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp, data_mem_resp;
    logic        instr_read;
    logic [31:0] if_ir;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b;
    logic [CNT_W-1:0] stall_cycles;

    wire [4:0] ld_o = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    wire [2:0] fl_o = {flush_if_id, flush_id_ex, flush_ex_mem};

    pipeline_hazard_unit #(.XLEN(32), .REG_IDX_W(5), .MC_CYCLES(MC), .CNT_W(CNT_W),
                           .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs(id_use_rs), .id_redirect(id_redirect),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_wr(ex_wr), .ex_load(ex_load), .ex_mc(ex_mc),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_load(mem_load), .mem_dreq(mem_dreq),
        .wb_rd(wb_rd), .wb_wr(wb_wr),
        .instr_mem_rdata(instr_mem_rdata), .instr_mem_resp(instr_mem_resp),
        .data_mem_resp(data_mem_resp),
        .instr_read(instr_read), .if_ir(if_ir),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_cycles(stall_cycles));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs = 0; id_redirect = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wr = 0; ex_load = 0; ex_mc = 0;
        mem_rd = 0; mem_wr = 0; mem_load = 0; mem_dreq = 0;
        wb_rd = 0; wb_wr = 0;
        instr_mem_rdata = 0; instr_mem_resp = 0; data_mem_resp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        rst = 1'b1;
    endtask

    // Single-cycle vectors applied from a freshly reset unit (fetch waiting, no multi-cycle op).
    typedef struct {
        int rs;
        int mwr, mld, mrd;
        int wwr, wrd;
        int exwr, exrd;
        int dreq, dresp, iresp, redir, mc;
        int fwd, ld, fl;
    } vec_t;
    vec_t vt[12];

    // Reference model state
    int          m_held, m_cnt, m_stall;
    logic [31:0] m_buf;
    int          k, e_ldv, e_flv;
    bit          hz, busy, rdy;
    int          rs_arr[2];

    function automatic int fwd_of(input int rs, input int mw, input int ml, input int mrd,
                                  input int ww, input int wrd);
        if (rs == 0) return 0;
        if (mw != 0 && ml == 0 && mrd == rs) return 1;
        if (ww != 0 && wrd == rs) return 2;
        return 0;
    endfunction

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Reset: controls forced low even with inputs that would drive them.
        instr_mem_resp = 1; mem_wr = 1; mem_rd = 1; ex_rs1 = 1; id_rs1 = 1;
        #1;
        chk("rst_loads", 32'(ld_o), 0);
        chk("rst_flush", 32'(fl_o), 0);
        chk("rst_iread", 32'(instr_read), 0);
        chk("rst_fwd", 32'({ex_fwd_a, id_fwd_a}), 0);
        step();
        chk("rst_stall", 32'(stall_cycles), 0);

        vt[0]  = '{1, 1,0,1, 0,0, 0,0, 0,0,1,0,0, 1, 'b11111, 'b000};
        vt[1]  = '{1, 1,0,1, 1,1, 0,0, 0,0,1,0,0, 1, 'b11111, 'b000};
        vt[2]  = '{0, 1,0,0, 1,0, 1,0, 0,0,1,0,0, 0, 'b11111, 'b000};
        vt[3]  = '{3, 1,0,4, 1,3, 0,0, 0,0,1,0,0, 2, 'b11111, 'b000};
        vt[4]  = '{3, 1,1,3, 1,3, 0,0, 0,0,1,0,0, 2, 'b00111, 'b010};
        vt[5]  = '{2, 0,0,0, 0,0, 1,2, 1,0,1,0,0, 0, 'b00000, 'b000};
        vt[6]  = '{2, 0,0,0, 0,0, 1,2, 1,1,1,0,0, 0, 'b00111, 'b010};
        vt[7]  = '{2, 0,0,0, 0,0, 1,2, 0,0,1,0,1, 0, 'b00011, 'b001};
        vt[8]  = '{0, 0,0,0, 0,0, 0,0, 0,0,0,0,0, 0, 'b01111, 'b100};
        vt[9]  = '{0, 0,0,0, 0,0, 0,0, 0,0,0,1,0, 0, 'b00111, 'b010};
        vt[10] = '{0, 0,0,0, 0,0, 0,0, 0,0,1,1,0, 0, 'b11111, 'b100};
        vt[11] = '{7, 1,0,7, 0,0, 1,6, 0,0,0,0,0, 1, 'b01111, 'b100};

        foreach (vt[i]) begin
            do_reset();
            id_rs1 = 5'(vt[i].rs); ex_rs1 = 5'(vt[i].rs); id_use_rs = 2'b01;
            mem_wr = vt[i].mwr[0]; mem_load = vt[i].mld[0]; mem_rd = 5'(vt[i].mrd);
            wb_wr = vt[i].wwr[0]; wb_rd = 5'(vt[i].wrd);
            ex_wr = vt[i].exwr[0]; ex_rd = 5'(vt[i].exrd);
            mem_dreq = vt[i].dreq[0]; data_mem_resp = vt[i].dresp[0];
            instr_mem_resp = vt[i].iresp[0]; id_redirect = vt[i].redir[0]; ex_mc = vt[i].mc[0];
            #1;
            chk($sformatf("vec%0d_exfwd", i), 32'(ex_fwd_a), 32'(vt[i].fwd));
            chk($sformatf("vec%0d_idfwd", i), 32'(id_fwd_a), 32'(vt[i].fwd));
            chk($sformatf("vec%0d_loads", i), 32'(ld_o), 32'(vt[i].ld));
            chk($sformatf("vec%0d_flush", i), 32'(fl_o), 32'(vt[i].fl));
        end

        // Load-use: lw x5 in EX, beq x5 in ID.
        do_reset();
        instr_mem_resp = 1; id_rs1 = 5; id_use_rs = 2'b01; ex_wr = 1; ex_load = 1; ex_rd = 5;
        #1;
        chk("lu_c0_pc", 32'(load_pc), 0);
        chk("lu_c0_flush_idex", 32'(flush_id_ex), 1);
        step();
        ex_wr = 0; ex_load = 0; ex_rd = 0; mem_wr = 1; mem_load = 1; mem_rd = 5;
        #1;
        chk("lu_c1_pc", 32'(load_pc), 0);
        step();
        mem_wr = 0; mem_load = 0; mem_rd = 0; wb_wr = 1; wb_rd = 5;
        #1;
        chk("lu_c2_fwd", 32'(id_fwd_a), 2);
        chk("lu_c2_pc", 32'(load_pc), 1);

        // D-cache wait with an I-fetch response landing mid-stall.
        do_reset();
        mem_dreq = 1;
        #1;
        chk("dc_c0_loads", 32'(ld_o), 0);
        step();
        instr_mem_resp = 1; instr_mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("dc_c1_loads", 32'(ld_o), 0);
        step();
        instr_mem_resp = 0; instr_mem_rdata = 32'h0;
        #1;
        chk("dc_c2_loads", 32'(ld_o), 0);
        chk("dc_c2_iread", 32'(instr_read), 0);
        step();
        data_mem_resp = 1;
        #1;
        chk("dc_ir", if_ir, 32'hDEAD_BEEF);
        chk("dc_iread", 32'(instr_read), 0);
        chk("dc_ld_ifid", 32'(load_if_id), 1);
        chk("dc_stall", 32'(stall_cycles), 3);

        // Multi-cycle EX op: three bubbles, then it leaves and a new one restarts the count.
        do_reset();
        ex_mc = 1; instr_mem_resp = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("mc_c%0d_flush", c), 32'(flush_ex_mem), (c != 3) ? 1 : 0);
            chk($sformatf("mc_c%0d_ldexmem", c), 32'(load_ex_mem), 1);
            step();
        end

        // Redirect while an instruction is held, then a redirect waiting on fetch.
        do_reset();
        instr_mem_resp = 1; instr_mem_rdata = 32'hCAFE_0001;
        id_rs1 = 1; id_use_rs = 2'b01; ex_wr = 1; ex_rd = 1;
        step();
        ex_wr = 0; instr_mem_resp = 0; instr_mem_rdata = 0; id_redirect = 1;
        #1;
        chk("rd_held_pc", 32'(load_pc), 1);
        chk("rd_held_flush", 32'(flush_if_id), 1);
        chk("rd_held_ir", if_ir, 32'hCAFE_0001);
        step();
        #1;
        chk("rd_wait_pc", 32'(load_pc), 0);
        chk("rd_wait_ifid", 32'(load_if_id), 0);
        chk("rd_wait_flush", 32'(flush_id_ex), 1);
        chk("rd_wait_iread", 32'(instr_read), 1);
        instr_mem_resp = 1;
        #1;
        chk("rd_resp_pc", 32'(load_pc), 1);
        chk("rd_resp_flush", 32'(flush_if_id), 1);

        // Reset while holding an instruction with the multi-cycle count part way.
        do_reset();
        ex_mc = 1; instr_mem_resp = 1;
        step();
        step();
        rst = 0; mem_wr = 1; mem_rd = 1; ex_rs1 = 1;
        #1;
        chk("mr_loads", 32'(ld_o), 0);
        chk("mr_flush", 32'(fl_o), 0);
        chk("mr_iread", 32'(instr_read), 0);
        chk("mr_fwd", 32'(ex_fwd_a), 0);
        step();
        rst = 1; instr_mem_resp = 0; mem_wr = 0;
        #1;
        chk("mr_post_iread", 32'(instr_read), 1);
        chk("mr_post_stall", 32'(stall_cycles), 0);
        chk("mr_post_flush0", 32'(flush_ex_mem), 1);
        step();
        step();
        #1;
        chk("mr_post_flush2", 32'(flush_ex_mem), 1);
        step();
        chk("mr_post_flush3", 32'(flush_ex_mem), 0);

        // Random traffic against the reference model.
        do_reset();
        m_held = 0; m_buf = 32'h0000_0013; m_cnt = 0; m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 31) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs = 2'($urandom); id_redirect = ($urandom_range(0, 3) == 0);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); ex_wr = 1'($urandom);
            ex_load = 1'($urandom); ex_mc = ($urandom_range(0, 3) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_wr = 1'($urandom); mem_load = 1'($urandom);
            mem_dreq = ($urandom_range(0, 3) == 0); data_mem_resp = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_wr = 1'($urandom);
            instr_mem_rdata = $urandom; instr_mem_resp = 1'($urandom);
            #1;
            rs_arr[0] = int'(id_rs1);
            rs_arr[1] = int'(id_rs2);
            hz = 0;
            for (int j = 0; j < 2; j++) begin
                if (id_use_rs[j] && rs_arr[j] != 0 &&
                    ((ex_wr && int'(ex_rd) == rs_arr[j]) || (mem_load && int'(mem_rd) == rs_arr[j])))
                    hz = 1;
            end
            busy = ex_mc && (m_cnt < MC - 1);
            rdy  = (m_held != 0) || instr_mem_resp;
            // k = number of leading registers frozen; the register just after them takes a bubble.
            if (mem_dreq && !data_mem_resp) k = 5;
            else if (busy) k = 3;
            else if (hz || (!rdy && id_redirect)) k = 2;
            else if (!rdy) k = 1;
            else k = 0;
            e_ldv = 0;
            e_flv = 0;
            for (int r = 0; r < 5; r++) begin
                if (r >= k) e_ldv |= 1 << (4 - r);
                if (r >= 1 && r <= 3 && ((r == k) || (k == 0 && r == 1 && id_redirect)))
                    e_flv |= 1 << (3 - r);
            end
            if (!rst) begin
                e_ldv = 0;
                e_flv = 0;
            end
            chk("rnd_loads", 32'(ld_o), e_ldv);
            chk("rnd_flush", 32'(fl_o), e_flv);
            chk("rnd_iread", 32'(instr_read), (rst && m_held == 0) ? 1 : 0);
            chk("rnd_ir", if_ir, (m_held != 0) ? m_buf : instr_mem_rdata);
            chk("rnd_fwd", 32'({id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b}),
                !rst ? 0 :
                ((fwd_of(int'(id_rs1), mem_wr, mem_load, int'(mem_rd), wb_wr, int'(wb_rd)) << 6) |
                 (fwd_of(int'(id_rs2), mem_wr, mem_load, int'(mem_rd), wb_wr, int'(wb_rd)) << 4) |
                 (fwd_of(int'(ex_rs1), mem_wr, mem_load, int'(mem_rd), wb_wr, int'(wb_rd)) << 2) |
                  fwd_of(int'(ex_rs2), mem_wr, mem_load, int'(mem_rd), wb_wr, int'(wb_rd))));
            chk("rnd_stall", 32'(stall_cycles), m_stall);
            @(posedge clk);
            if (!rst) begin
                m_held = 0; m_buf = 32'h0000_0013; m_cnt = 0; m_stall = 0;
            end else begin
                if (e_ldv[1] && !e_flv[0]) m_cnt = 0;
                else if (busy) m_cnt++;
                if (m_held == 0 && instr_mem_resp && !e_ldv[4]) begin
                    m_held = 1;
                    m_buf = instr_mem_rdata;
                end else if (m_held != 0 && e_ldv[4]) begin
                    m_held = 0;
                end
                if (!e_ldv[4] && m_stall < SAT) m_stall++;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
